// File: rtl/calc_op_sequencer.sv
// calc_op_sequencer
// Control FSM that sits between the debounced operator buttons and the
// calculator ALU / 4-entry result memory.
//   - A rising edge on a button becomes a single request. Requests are only
//     accepted in IDLE. When several edges arrive together the priority is
//     add > sub > mul > div.
//   - Operands are captured from sw, one ALU operation is started, and the
//     FSM waits for alu_done. The result is then written to the memory slot
//     selected by the opcode, and it is copied to disp_value.
//   - A divide by zero skips the ALU. An ALU that never answers is timed out.
//     In both cases 16'hFFFF is written and a sticky error flag is set.
// Ports
//   clk, reset                       clock and synchronous active-high reset
//   btn_add/sub/mul/div              debounced button levels
//   sw[15:8]=A, sw[7:0]=B            operands
//   alu_result, alu_done             ALU response (done is looked at only in WAIT)
//   alu_start                        one-cycle start pulse
//   opcode, op_a, op_b               latched operation (mul=0 div=1 sub=2 add=3)
//   mem_we, mem_oe, mem_addr, mem_wdata   result memory port
//   disp_value                       last committed result
//   busy, err_div0, err_timeout      status
module calc_op_sequencer #(
    parameter int TIMEOUT_CYCLES = 300,
    parameter int DATA_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_add,
    input  logic              btn_sub,
    input  logic              btn_mul,
    input  logic              btn_div,
    input  logic [15:0]       sw,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_done,
    output logic              alu_start,
    output logic [1:0]        opcode,
    output logic [7:0]        op_a,
    output logic [7:0]        op_b,
    output logic              mem_we,
    output logic              mem_oe,
    output logic [1:0]        mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] disp_value,
    output logic              busy,
    output logic              err_div0,
    output logic              err_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] OP_MUL = 2'd0;
    localparam logic [1:0] OP_DIV = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_ADD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        btn_prev_q, btn_prev_d;
    logic [1:0]        opcode_q, opcode_d;
    logic [7:0]        op_a_q, op_a_d;
    logic [7:0]        op_b_q, op_b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] disp_q, disp_d;
    logic              err_div0_q, err_div0_d;
    logic              err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Button vector ordered {add, sub, mul, div}.
    logic [3:0] btn_now;
    logic [3:0] req;

    assign btn_now = {btn_add, btn_sub, btn_mul, btn_div};

    for (genvar gi = 0; gi < 4; gi++) begin : g_req
        assign req[gi] = btn_now[gi] & ~btn_prev_q[gi];
    end

    always_comb begin
        state_d       = state_q;
        btn_prev_d    = btn_now;
        opcode_d      = opcode_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        result_d      = result_q;
        disp_d        = disp_q;
        err_div0_d    = err_div0_q;
        err_timeout_d = err_timeout_q;
        cnt_d         = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    // Fixed priority; lower-priority edges in the same cycle are lost.
                    if (req[3])      opcode_d = OP_ADD;
                    else if (req[2]) opcode_d = OP_SUB;
                    else if (req[1]) opcode_d = OP_MUL;
                    else             opcode_d = OP_DIV;
                    op_a_d        = sw[15:8];
                    op_b_d        = sw[7:0];
                    err_div0_d    = 1'b0;
                    err_timeout_d = 1'b0;
                    if (!req[3] && !req[2] && !req[1] && sw[7:0] == 8'd0) begin
                        // Division by zero never reaches the ALU.
                        err_div0_d = 1'b1;
                        result_d   = '1;
                        state_d    = ST_WRITE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // alu_done takes precedence over an expiring timeout.
                if (alu_done) begin
                    result_d = alu_result;
                    state_d  = ST_WRITE;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_timeout_d = 1'b1;
                    result_d      = '1;
                    state_d       = ST_WRITE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WRITE: begin
                disp_d  = result_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            // A button held through reset must not look like a fresh press.
            btn_prev_q    <= btn_now;
            opcode_q      <= '0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            result_q      <= '0;
            disp_q        <= '0;
            err_div0_q    <= 1'b0;
            err_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            btn_prev_q    <= btn_prev_d;
            opcode_q      <= opcode_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            result_q      <= result_d;
            disp_q        <= disp_d;
            err_div0_q    <= err_div0_d;
            err_timeout_q <= err_timeout_d;
            cnt_q         <= cnt_d;
        end
    end

    assign alu_start   = (state_q == ST_ISSUE);
    assign mem_we      = (state_q == ST_WRITE);
    // In IDLE the memory reads back the slot of the last operation.
    assign mem_oe      = (state_q == ST_IDLE);
    assign mem_addr    = opcode_q;
    assign mem_wdata   = (state_q == ST_WRITE) ? result_q : '0;
    assign busy        = (state_q != ST_IDLE);
    assign opcode      = opcode_q;
    assign op_a        = op_a_q;
    assign op_b        = op_b_q;
    assign disp_value  = disp_q;
    assign err_div0    = err_div0_q;
    assign err_timeout = err_timeout_q;

endmodule
